// File: rtl/ecc_104_enc_wr.sv
// Write-side SECDED encoder for 104-bit FIFO/RAM words.
// Duplicated encoders are cross-checked, with bounded retry and fault flagging.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ecc_fault_detc_en  enable comparison of the two encoders
//   bypass             force parity_out to 0, skip comparison
//   fault_inj          invert bit 0 of encoder-1 parity (test hook)
//   fault_cnt_clr      synchronous clear of fault_cnt
//   in_valid/in_ready  input handshake, data_in word
//   out_valid/out_ready output handshake, data_out + parity_out
//   out_fault          current output produced after exhausting retries
//   ecc_fault          one-cycle pulse when a fault is declared
//   fault_cnt          saturating count of declared faults

module ecc_104_enc_core #(
    parameter int DATA_WIDTH   = 104,
    parameter int PARITY_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   data,
    output logic [PARITY_WIDTH-1:0] parity
);

    // Data bit k sits at the k-th non-power-of-two position (3, 5, 6, 7, 9 ...).
    function automatic logic [7:0] secded(input logic [103:0] d);
        logic [6:0] h;
        logic       p;
        int         k;
        h = '0;
        k = 0;
        for (int pos = 1; pos < 112; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < 7; i++) begin
                    if (pos[i]) begin
                        h[i] = h[i] ^ d[k];
                    end
                end
                k++;
            end
        end
        p = (^d) ^ (^h);
        return {p, h};
    endfunction

    assign parity = secded(data);

endmodule

module ecc_104_enc_wr #(
    parameter int DATA_WIDTH   = 104,
    parameter int PARITY_WIDTH = 8,
    parameter int MAX_RETRY    = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    fault_inj,
    input  logic                    fault_cnt_clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    out_fault,
    output logic                    ecc_fault,
    output logic [CNT_WIDTH-1:0]    fault_cnt
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [PARITY_WIDTH-1:0] parity_reg;
    logic [RW-1:0]           retry_cnt;
    logic [PARITY_WIDTH-1:0] enc0;
    logic [PARITY_WIDTH-1:0] enc1_raw;
    logic [PARITY_WIDTH-1:0] enc1;
    logic                    match;
    logic                    retry_left;
    logic                    declare;

    ecc_104_enc_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_WIDTH(PARITY_WIDTH)
    ) u_enc0 (
        .data  (data_reg),
        .parity(enc0)
    );

    ecc_104_enc_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_WIDTH(PARITY_WIDTH)
    ) u_enc1 (
        .data  (data_reg),
        .parity(enc1_raw)
    );

    assign enc1 = enc1_raw ^ {{(PARITY_WIDTH-1){1'b0}}, fault_inj};

    assign match      = (enc0 == enc1) || !ecc_fault_detc_en || bypass;
    assign retry_left = retry_cnt < RW'(MAX_RETRY);
    assign declare    = (state == CALC) && !match && !retry_left;

    assign in_ready   = (state == IDLE) || ((state == OUT) && out_ready);
    assign out_valid  = (state == OUT);
    assign data_out   = data_reg;
    assign parity_out = parity_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            data_reg   <= '0;
            parity_reg <= '0;
            retry_cnt  <= '0;
            out_fault  <= 1'b0;
            ecc_fault  <= 1'b0;
            fault_cnt  <= '0;
        end else begin
            ecc_fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg  <= data_in;
                        retry_cnt <= '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (match) begin
                        parity_reg <= bypass ? '0 : enc0;
                        out_fault  <= 1'b0;
                        state      <= OUT;
                    end else if (retry_left) begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end else begin
                        parity_reg <= enc0;
                        out_fault  <= 1'b1;
                        ecc_fault  <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            data_reg  <= data_in;
                            retry_cnt <= '0;
                            state     <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear wins over a same-cycle increment.
            if (fault_cnt_clr) begin
                fault_cnt <= '0;
            end else if (declare && (fault_cnt != {CNT_WIDTH{1'b1}})) begin
                fault_cnt <= fault_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_104_enc_wr.sv
// Bench for ecc_104_enc_wr: directed vector table plus handshake,
// reset and counter corner sequences.

module tb_ecc_104_enc_wr;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, byp, inj, clr;
    logic         in_valid, in_ready;
    logic [103:0] data_in;
    logic         out_valid, out_ready;
    logic [103:0] data_out;
    logic [7:0]   parity_out;
    logic         out_fault, ecc_fault;
    logic [7:0]   fault_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    ecc_104_enc_wr dut (
        .clk              (clk),
        .rst              (rst),
        .ecc_fault_detc_en(en),
        .bypass           (byp),
        .fault_inj        (inj),
        .fault_cnt_clr    (clr),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .data_in          (data_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .data_out         (data_out),
        .parity_out       (parity_out),
        .out_fault        (out_fault),
        .ecc_fault        (ecc_fault),
        .fault_cnt        (fault_cnt)
    );

    typedef struct {
        logic [103:0] d;
        logic         byp;
        logic         en;
        logic         inj;
        logic [7:0]   par;
        logic         flt;
        int           lat;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge
    // where out_valid is first seen (or after a bounded wait).
    task automatic send(input logic [103:0] d, output int lat,
                        output int pulses);
        data_in  = d;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat    = 1;
        pulses = 0;
        while (!out_valid && lat < 20) begin
            pulses += int'(ecc_fault);
            @(negedge clk);
            lat++;
        end
        pulses += int'(ecc_fault);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, pulses;
        logic [103:0] hd;
        logic [7:0]   hp;
        logic [103:0] words[4];
        logic [103:0] got[$];
        int           tstamp[$];
        int           idx, cyc, acc;

        vt[0]  = '{104'h0, 0, 1, 0, 8'h00, 0, 2};
        vt[1]  = '{104'h1, 0, 1, 0, 8'h83, 0, 2};
        vt[2]  = '{104'h2, 0, 1, 0, 8'h85, 0, 2};
        vt[3]  = '{104'h3, 0, 1, 0, 8'h06, 0, 2};
        vt[4]  = '{104'h10, 0, 1, 0, 8'h89, 0, 2};
        vt[5]  = '{104'h1 << 103, 0, 1, 0, 8'hEF, 0, 2};
        vt[6]  = '{{104{1'b1}}, 0, 1, 0, 8'hFF, 0, 2};
        vt[7]  = '{104'h1, 0, 1, 1, 8'h83, 1, 4};
        vt[8]  = '{104'h2, 0, 0, 1, 8'h85, 0, 2};
        vt[9]  = '{104'h3, 1, 1, 1, 8'h00, 0, 2};
        vt[10] = '{104'h3, 0, 1, 0, 8'h06, 0, 2};

        rst = 1'b1;
        en = 1'b1; byp = 1'b0; inj = 1'b0; clr = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        #23;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_parity", parity_out, 0);
        check("rst_cnt", fault_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            byp = vt[i].byp;
            en  = vt[i].en;
            inj = vt[i].inj;
            send(vt[i].d, lat, pulses);
            if (vt[i].flt) exp_cnt++;
            check($sformatf("v%0d_lat", i), lat, vt[i].lat);
            check($sformatf("v%0d_par", i), parity_out, vt[i].par);
            check($sformatf("v%0d_data", i), data_out, vt[i].d);
            check($sformatf("v%0d_flt", i), out_fault, vt[i].flt);
            check($sformatf("v%0d_pulse", i), pulses, int'(vt[i].flt));
            check($sformatf("v%0d_cnt", i), fault_cnt, exp_cnt);
            drain();
        end
        byp = 1'b0; en = 1'b1; inj = 1'b0;

        // Stall: output held while out_ready stays low.
        hd = 104'h1 << 103;
        send(hd, lat, pulses);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = 104'h5;
            check("stall_valid", out_valid, 1);
            check("stall_data", data_out, hd);
            check("stall_par", parity_out, 8'hEF);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        drain();

        // Back-to-back words with out_ready held high.
        words[0] = 104'h1;
        words[1] = 104'h2;
        words[2] = 104'h3;
        words[3] = {104{1'b1}};
        idx = 0;
        cyc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = words[0];
        while (got.size() < 4 && cyc < 40) begin
            acc = int'(in_valid && in_ready);
            if (out_valid) begin
                got.push_back(data_out);
                tstamp.push_back(cyc);
                hp = parity_out;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc != 0) idx++;
            if (idx < 4) data_in = words[idx];
            else in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            check($sformatf("b2b_word%0d", i), got[i], words[i]);
            if (i > 0)
                check($sformatf("b2b_gap%0d", i),
                      tstamp[i] - tstamp[i-1], 2);
        end
        check("b2b_last_par", hp, 8'hFF);
        @(negedge clk);

        // Reset while retrying.
        inj      = 1'b1;
        data_in  = 104'h2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rr_out_valid", out_valid, 0);
        check("rr_in_ready", in_ready, 1);
        check("rr_data", data_out, 0);
        check("rr_par", parity_out, 0);
        check("rr_flt", out_fault, 0);
        check("rr_ecc", ecc_fault, 0);
        check("rr_cnt", fault_cnt, 0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Saturation of the fault counter.
        for (int i = 0; i < 256; i++) begin
            send(104'h1, lat, pulses);
            drain();
        end
        check("sat_ff", fault_cnt, 8'hFF);
        send(104'h1, lat, pulses);
        check("sat_hold", fault_cnt, 8'hFF);
        check("sat_pulse", pulses, 1);
        drain();

        // Clear held across a fault declaration wins.
        clr = 1'b1;
        send(104'h1, lat, pulses);
        check("clr_prio", fault_cnt, 0);
        clr = 1'b0;
        drain();
        send(104'h1, lat, pulses);
        check("after_clr", fault_cnt, 1);
        drain();
        inj = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_104_enc_wr.md
Name: ecc_104_enc_wr

Overview:
- Write-side SECDED encoder for 104-bit FIFO/RAM words. It generates the 8 check bits that the read-side decode/fault-detect path consumes.
- Two redundant encoder instances evaluate the same registered word and their results are compared. On a mismatch the block retries a bounded number of times, then delivers the word flagged and raises a fault indication.
- Valid/ready handshakes on both sides. It sits between the FIFO write port and the storage array.

Parameters:
- DATA_WIDTH, 104, data word width. Only 104 is supported.
- PARITY_WIDTH, 8, check bits: 7 Hamming bits plus 1 overall parity bit.
- MAX_RETRY, 2, number of re-evaluations allowed after a mismatch before a fault is declared.
- CNT_WIDTH, 8, width of the saturating fault counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- ecc_fault_detc_en  input  1  enables redundant comparison. When 0, encoder 0 is trusted.
- bypass  input  1  forces parity_out to 0 and skips the comparison.
- fault_inj  input  1  test hook: inverts bit 0 of encoder-1 parity.
- fault_cnt_clr  input  1  synchronous clear of fault_cnt.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- data_in  input  DATA_WIDTH  word to encode.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts.
- data_out  output  DATA_WIDTH  registered copy of the accepted word.
- parity_out  output  PARITY_WIDTH  check bits.
- out_fault  output  1  current output word was produced after exhausting retries.
- ecc_fault  output  1  one-cycle pulse when a fault is declared.
- fault_cnt  output  CNT_WIDTH  saturating count of declared faults.

Behaviour:
- Code definition:
  - Data bit k maps to the k-th non-power-of-two codeword position, ascending from 1. So d0 is at position 3, d1 at 5, d2 at 6, d3 at 7, d4 at 9, …, and d103 at 111.
  - parity[i] for i = 0..6 is the XOR of the data bits whose position has bit i set.
  - parity[7] is the XOR of all 104 data bits and parity[6:0].
- Both encoders are purely combinational on data_reg. Only encoder 0 drives parity_out.
- match means enc0 parity equals enc1 parity, or ecc_fault_detc_en = 0, or bypass = 1.
- State machine with states IDLE, CALC, OUT:
  - IDLE: in_ready = 1. On in_valid, data_reg <= data_in, retry_cnt <= 0, go to CALC.
  - CALC: in_ready = 0.
    - If match: parity_reg <= enc0 (or 0 if bypass), out_fault <= 0, go to OUT.
    - Else if retry_cnt < MAX_RETRY: retry_cnt++, stay in CALC, re-evaluate.
    - Else: parity_reg <= enc0, out_fault <= 1, pulse ecc_fault for 1 cycle, fault_cnt++ (saturating at all-ones), go to OUT.
  - OUT: out_valid = 1. data_out and parity_out stay stable until out_ready.
    - in_ready = out_ready.
    - On out_ready with in_valid: capture the new word, retry_cnt <= 0, go to CALC.
    - On out_ready without in_valid: go to IDLE.
- Latency: a word accepted at edge T produces out_valid after edge T+1 when there is no retry. Each retry adds 1 cycle.
- Throughput: 1 word per 2 cycles with out_ready held high.
- fault_cnt_clr has priority over the increment when both occur in the same cycle.
- Reset, asynchronous, from any state: state = IDLE, in_ready = 1, out_valid = 0, data_out = 0, parity_out = 0, out_fault = 0, ecc_fault = 0, fault_cnt = 0, retry_cnt = 0. An in-flight word is discarded.
- The bypass, ecc_fault_detc_en and fault_inj values are those sampled in the CALC cycle.
- out_valid must never deassert without out_ready. in_valid ignored while in_ready = 0.

Test Plan:
1. data_in = 0, en = 1, out_ready = 1 → out_valid 1 cycle after accept; parity_out = 8'h00; out_fault = 0.
2. data_in = 104'h1 → parity_out = 8'h83. data_in = 104'h2 → 8'h85. Then data_in = 104'h3 → 8'h06.
3. fault_inj = 1, en = 1, MAX_RETRY = 2 → CALC lasts 3 cycles; ecc_fault pulses once; out_fault = 1; fault_cnt = 1; parity_out = encoder-0 value.
4. fault_inj = 1 with en = 0, or with bypass = 1 → no retry, ecc_fault = 0. With bypass = 1, parity_out = 0.
5. out_ready = 0 for 5 cycles → data_out and parity_out held, in_ready = 0. Then back-to-back words with out_ready = 1 → one output every 2 cycles, no word lost.
6. Assert rst in CALC during a retry → all outputs at reset values next cycle. fault_cnt at 8'hFF plus another fault → stays 8'hFF. fault_cnt_clr → 0.
